// File: rtl/pwm_servo_bank_pkg.sv
// ---------------------------------------------------------------------------
// pwm_servo_bank_pkg
// Shared constants and helpers for the servo/ESC pulse bank.
//   - DEF_* : default frame, limit and channel constants
//   - clog2 : counter width helper (never returns less than 1)
//   - pw_width : pulse-width datapath width for a given command width
//   - ch_lsb : base bit of channel ch inside a packed channel bus
// ---------------------------------------------------------------------------
package pwm_servo_bank_pkg;

    localparam int DEF_N_CH           = 4;
    localparam int DEF_CMD_W          = 10;
    localparam int DEF_CLK_DIV        = 50;
    localparam int DEF_FRAME_US       = 2500;
    localparam int DEF_MAX_PULSE_US   = 2000;
    localparam int DEF_TIMEOUT_FRAMES = 20;
    localparam int DEF_SLEW_STEP      = 16;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // offset + command never wraps with one extra bit
    function automatic int pw_width(input int cmd_w);
        return cmd_w + 1;
    endfunction

    function automatic int ch_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pwm_servo_channel.sv
// ---------------------------------------------------------------------------
// pwm_servo_channel
// One output channel: active command register (optionally slew limited),
// saturating offset adder and registered pulse compare.
// Optional feature macro: PWM_SERVO_BANK_SLEW_EN (slew-limited command load).
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   boundary   : last cycle of the frame; next-frame values are latched
//   load       : shadow command pending, active_cmd moves toward target
//   target     : shadow command for this channel
//   offset_d   : pulse offset in force for the coming cycle
//   armed_d    : arm state in force for the coming cycle
//   fcnt_d     : frame counter value for the coming cycle
//   servo      : registered pulse output
//   at_target  : active_cmd will equal target after this cycle
// ---------------------------------------------------------------------------
module pwm_servo_channel
    import pwm_servo_bank_pkg::*;
#(
    parameter int CMD_W        = DEF_CMD_W,
    parameter int FC_W         = 13,
    parameter int MAX_PULSE_US = DEF_MAX_PULSE_US,
    parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             boundary,
    input  logic             load,
    input  logic [CMD_W-1:0] target,
    input  logic [CMD_W-1:0] offset_d,
    input  logic             armed_d,
    input  logic [FC_W-1:0]  fcnt_d,
    output logic             servo,
    output logic             at_target
);

    localparam int PWW = pw_width(CMD_W);

`ifdef PWM_SERVO_BANK_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    logic [CMD_W-1:0] active_cmd;
    logic [CMD_W-1:0] active_d;
    logic [CMD_W-1:0] eff_cmd;
    logic [PWW-1:0]   pw;
    logic [PWW-1:0]   pw_d;

    // Step toward tgt by at most SLEW_STEP, landing exactly on tgt
    function automatic logic [CMD_W-1:0] step_toward(input logic [CMD_W-1:0] cur,
                                                     input logic [CMD_W-1:0] tgt);
        logic [CMD_W-1:0] diff;
        if (!SLEW_ON) return tgt;
        if (tgt >= cur) begin
            diff = tgt - cur;
            if (32'(diff) > SLEW_STEP) return cur + CMD_W'(SLEW_STEP);
            return tgt;
        end
        diff = cur - tgt;
        if (32'(diff) > SLEW_STEP) return cur - CMD_W'(SLEW_STEP);
        return tgt;
    endfunction

    // offset + command at PWW bits, clamped to MAX_PULSE_US
    function automatic logic [PWW-1:0] sat_pw(input logic [CMD_W-1:0] ofs,
                                              input logic [CMD_W-1:0] cmd);
        logic [PWW-1:0] sum;
        sum = PWW'(ofs) + PWW'(cmd);
        if (32'(sum) > MAX_PULSE_US) return PWW'(MAX_PULSE_US);
        return sum;
    endfunction

    // Next-frame values are computed combinationally so the pulse can rise
    // in the very first cycle of the new frame.
    always_comb begin
        active_d = active_cmd;
        if (boundary && load) active_d = step_toward(active_cmd, target);
        at_target = (active_d == target);
        eff_cmd   = armed_d ? active_d : '0;
        pw_d      = boundary ? sat_pw(offset_d, eff_cmd) : pw;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            active_cmd <= '0;
            pw         <= '0;
            servo      <= 1'b0;
        end else begin
            active_cmd <= active_d;
            pw         <= pw_d;
            servo      <= (fcnt_d < FC_W'(pw_d));
        end
    end

endmodule

// File: rtl/pwm_servo_bank.sv
// ---------------------------------------------------------------------------
// pwm_servo_bank
// N-channel servo/ESC pulse generator sharing one frame timer. Commands are
// double buffered (shadow -> active at frame boundary), with arm/disarm,
// command-loss watchdog and pulse saturation.
// Optional feature macro: PWM_SERVO_BANK_SLEW_EN (per-frame slew limit).
// Ports:
//   CLK         : system clock
//   RST_N       : asynchronous active-low reset
//   CMD         : packed channel commands, channel i at [i*CMD_W +: CMD_W]
//   CMD_VALID   : one-cycle strobe, writes CMD into the shadow registers
//   OFFSET      : offset added to every command (latched at boundary)
//   ARM         : 1 = commands applied, 0 = commands forced to 0
//   SERVO       : pulse outputs
//   FRAME_START : one-cycle pulse in the first cycle of each frame
//   TIMEOUT     : watchdog failsafe active
//   ARMED       : arm state in force for the current frame
// ---------------------------------------------------------------------------
module pwm_servo_bank
    import pwm_servo_bank_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int CMD_W          = DEF_CMD_W,
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int FRAME_US       = DEF_FRAME_US,
    parameter int MAX_PULSE_US   = DEF_MAX_PULSE_US,
    parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES,
    parameter int SLEW_STEP      = DEF_SLEW_STEP
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [N_CH*CMD_W-1:0] CMD,
    input  logic                  CMD_VALID,
    input  logic [CMD_W-1:0]      OFFSET,
    input  logic                  ARM,
    output logic [N_CH-1:0]       SERVO,
    output logic                  FRAME_START,
    output logic                  TIMEOUT,
    output logic                  ARMED
);

    localparam int PS_W = clog2(CLK_DIV);
    // one spare bit so a pulse width always fits the compare width
    localparam int FC_W = clog2(FRAME_US) + 1;
    localparam int WD_W = clog2(TIMEOUT_FRAMES + 2);

    logic [PS_W-1:0]       presc;
    logic                  tick;
    logic [FC_W-1:0]       fcnt;
    logic [FC_W-1:0]       fcnt_d;
    logic                  boundary;
    logic [N_CH*CMD_W-1:0] shadow;
    logic                  pending;
    logic [CMD_W-1:0]      offset_act;
    logic [CMD_W-1:0]      offset_d;
    logic                  armed_d;
    logic [WD_W-1:0]       wdog;
    logic [WD_W-1:0]       wdog_inc;
    logic                  timeout_next;
    logic [N_CH-1:0]       at_target;

    always_comb begin
        tick     = (presc == PS_W'(CLK_DIV - 1));
        boundary = tick && (fcnt == FC_W'(FRAME_US - 1));
        fcnt_d   = fcnt;
        if (tick) fcnt_d = boundary ? '0 : fcnt + 1'b1;

        wdog_inc = (32'(wdog) >= TIMEOUT_FRAMES) ? wdog : wdog + 1'b1;
        // a CMD_VALID in the boundary cycle still counts for the ending frame
        timeout_next = (TIMEOUT_FRAMES != 0) && !CMD_VALID &&
                       (32'(wdog_inc) >= TIMEOUT_FRAMES);

        armed_d  = boundary ? (ARM && !timeout_next) : ARMED;
        offset_d = boundary ? OFFSET : offset_act;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc       <= '0;
            fcnt        <= '0;
            FRAME_START <= 1'b0;
            TIMEOUT     <= 1'b0;
            ARMED       <= 1'b0;
            offset_act  <= '0;
            wdog        <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
        end else begin
            presc       <= tick ? '0 : presc + 1'b1;
            fcnt        <= fcnt_d;
            FRAME_START <= boundary;
            if (boundary) begin
                TIMEOUT    <= timeout_next;
                ARMED      <= armed_d;
                offset_act <= OFFSET;
            end

            if (CMD_VALID)     wdog <= '0;
            else if (boundary) wdog <= wdog_inc;

            // A write in the boundary cycle stays pending for the next frame;
            // with slew limiting, pending holds until every channel arrives.
            if (CMD_VALID) begin
                shadow  <= CMD;
                pending <= 1'b1;
            end else if (boundary && (&at_target)) begin
                pending <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_servo_channel #(
            .CMD_W        (CMD_W),
            .FC_W         (FC_W),
            .MAX_PULSE_US (MAX_PULSE_US),
            .SLEW_STEP    (SLEW_STEP)
        ) u_ch (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .boundary  (boundary),
            .load      (pending),
            .target    (shadow[ch_lsb(g, CMD_W) +: CMD_W]),
            .offset_d  (offset_d),
            .armed_d   (armed_d),
            .fcnt_d    (fcnt_d),
            .servo     (SERVO[g]),
            .at_target (at_target[g])
        );
    end

endmodule

// File: tb/tb_pwm_servo_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_servo_bank
// Directed bench for pwm_servo_bank: 4 channels, CLK_DIV=2, FRAME_US=1100
// (2200 cycles per frame), MAX_PULSE_US=1050, TIMEOUT_FRAMES=3.
// Pulse widths are measured in cycles per frame, delimited by FRAME_START.
// ---------------------------------------------------------------------------
module tb_pwm_servo_bank;

    localparam int N_CH = 4;
    localparam int CMD_W = 10;
    localparam int FRAME_CYC = 2200;

    logic                  CLK = 1'b0;
    logic                  RST_N;
    logic [N_CH*CMD_W-1:0] CMD;
    logic                  CMD_VALID;
    logic [CMD_W-1:0]      OFFSET;
    logic                  ARM;
    logic [N_CH-1:0]       SERVO;
    logic                  FRAME_START;
    logic                  TIMEOUT;
    logic                  ARMED;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fs_cyc = 0;
    bit fs_seen = 0;
    int hi [N_CH];
    int wid [N_CH];

    always #5 CLK = ~CLK;

    pwm_servo_bank #(
        .N_CH           (N_CH),
        .CMD_W          (CMD_W),
        .CLK_DIV        (2),
        .FRAME_US       (1100),
        .MAX_PULSE_US   (1050),
        .TIMEOUT_FRAMES (3),
        .SLEW_STEP      (16)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .CMD         (CMD),
        .CMD_VALID   (CMD_VALID),
        .OFFSET      (OFFSET),
        .ARM         (ARM),
        .SERVO       (SERVO),
        .FRAME_START (FRAME_START),
        .TIMEOUT     (TIMEOUT),
        .ARMED       (ARMED)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N_CH*CMD_W-1:0] pack4(input int a, input int b,
                                                     input int c, input int d);
        return {CMD_W'(d), CMD_W'(c), CMD_W'(b), CMD_W'(a)};
    endfunction

    task automatic clear_meas();
        cyc = 0;
        for (int i = 0; i < N_CH; i++) hi[i] = 0;
    endtask

    // advance one cycle, sample on the falling edge
    task automatic step();
        @(negedge CLK);
        cyc++;
        fs_seen = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (FRAME_START) begin
                wid[i] = hi[i];
                hi[i]  = int'(SERVO[i]);
            end else begin
                hi[i] += int'(SERVO[i]);
            end
        end
        if (FRAME_START) begin
            fs_seen = 1;
            fs_cyc  = cyc;
        end
    endtask

    task automatic run_to_fs();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!fs_seen && n < FRAME_CYC + 800);
        if (!fs_seen) chk("frame_start_timeout", 0, 1);
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic send(input logic [N_CH*CMD_W-1:0] v);
        CMD = v;
        CMD_VALID = 1'b1;
        step();
        CMD_VALID = 1'b0;
    endtask

    task automatic chk_wid(input string tag, input int e0, input int e1,
                           input int e2, input int e3);
        int e [N_CH];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < N_CH; i++)
            chk($sformatf("%s_ch%0d", tag, i), wid[i], e[i]);
    endtask

    initial begin
        RST_N = 1'b0;
        CMD = '0;
        CMD_VALID = 1'b0;
        OFFSET = 10'd100;
        ARM = 1'b1;
        for (int i = 0; i < N_CH; i++) wid[i] = -1;
        repeat (3) @(negedge CLK);
        chk("rst_servo", SERVO, 0);
        chk("rst_frame_start", FRAME_START, 0);
        chk("rst_timeout", TIMEOUT, 0);
        chk("rst_armed", ARMED, 0);

        RST_N = 1'b1;
        clear_meas();
        run_to_fs();
        chk("first_fs_cycle", fs_cyc, 2200);
        chk_wid("frame0", 0, 0, 0, 0);
        chk("frame1_armed", ARMED, 1);

`ifdef PWM_SERVO_BANK_SLEW_EN
        OFFSET = 10'd0;
        run_until(fs_cyc + 1000);
        send(pack4(100, 100, 100, 100));
        run_to_fs();
        for (int j = 1; j <= 7; j++) begin
            if (j % 2 == 0) begin
                run_until(fs_cyc + 1000);
                send(pack4(100, 100, 100, 100));
            end
            run_to_fs();
            chk_wid($sformatf("slew_f%0d", j), 2 * ((16 * j > 100) ? 100 : 16 * j),
                    2 * ((16 * j > 100) ? 100 : 16 * j),
                    2 * ((16 * j > 100) ? 100 : 16 * j),
                    2 * ((16 * j > 100) ? 100 : 16 * j));
            if (j == 3) chk("slew_pending_mid", dut.pending, 1);
        end
        chk("slew_pending_done", dut.pending, 0);
        chk("slew_timeout", TIMEOUT, 0);
`else
        // command mid-frame: current frame unchanged, next frame updated
        run_until(fs_cyc + 1000);
        send(pack4(300, 0, 500, 1023));
        run_to_fs();
        chk("fs_period", fs_cyc, 4400);
        chk_wid("frame1", 200, 200, 200, 200);
        run_to_fs();
        chk_wid("frame2", 800, 200, 1200, 2100);

        // command exactly in the boundary cycle: applied one frame later
        run_until(fs_cyc + FRAME_CYC - 1);
        send(pack4(200, 200, 200, 200));
        chk("fs_after_b_cmd", fs_cyc, 8800);
        chk_wid("frame3", 800, 200, 1200, 2100);
        run_to_fs();
        chk_wid("frame4_old_cmd", 800, 200, 1200, 2100);
        run_to_fs();
        chk_wid("frame5_new_cmd", 600, 600, 600, 600);
        chk("pre_timeout", TIMEOUT, 0);
        chk("pre_timeout_armed", ARMED, 1);
        run_to_fs();
        chk("timeout_set", TIMEOUT, 1);
        chk("timeout_disarm", ARMED, 0);
        chk_wid("frame6", 600, 600, 600, 600);

        // timeout frame: offset only; one write clears the failsafe
        run_until(fs_cyc + 1000);
        send(pack4(50, 60, 70, 80));
        run_to_fs();
        chk_wid("frame_timeout", 200, 200, 200, 200);
        chk("timeout_clear", TIMEOUT, 0);
        chk("rearm_after_timeout", ARMED, 1);

        // drop ARM while pulses are high: current pulses complete
        run_until(fs_cyc + 100);
        ARM = 1'b0;
        send(pack4(50, 60, 70, 80));
        run_to_fs();
        chk_wid("arm_drop_frame", 300, 320, 340, 360);
        chk("disarmed", ARMED, 0);

        // OFFSET change mid-frame only lands at the boundary
        run_until(fs_cyc + 50);
        OFFSET = 10'd0;
        send(pack4(50, 60, 70, 80));
        run_to_fs();
        chk_wid("disarmed_frame", 200, 200, 200, 200);
        chk("still_disarmed", ARMED, 0);

        run_until(fs_cyc + 50);
        ARM = 1'b1;
        send(pack4(50, 60, 70, 80));
        run_to_fs();
        chk_wid("zero_pw_frame", 0, 0, 0, 0);
        chk("rearmed", ARMED, 1);

        // asynchronous reset in the middle of a pulse
        run_until(fs_cyc + 20);
        chk("servo_high_before_rst", SERVO, 4'hF);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_servo", SERVO, 0);
        chk("async_rst_armed", ARMED, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        clear_meas();
        run_to_fs();
        chk("restart_fs_cycle", fs_cyc, 2200);
        chk_wid("restart_frame0", 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_servo_bank.md
Name: pwm_servo_bank

Overview:
Parametrised N-channel servo/ESC pulse generator that drives all motor outputs from one shared frame timer.
- Commands are double-buffered and applied only at frame boundaries, so a pulse is never torn mid-frame.
- Adds arm/disarm, a command-loss watchdog and output saturation.
- Sits between the motor mixer / test-latch mux and the MOTOR pins, and replaces per-motor servo instances.

Parameters:
N_CH, 4, number of output channels
CMD_W, 10, command and offset width (µs units)
CLK_DIV, 50, CLK cycles per 1 µs tick (≥2)
FRAME_US, 2500, frame period in µs (≥ 2^CMD_W + 2)
MAX_PULSE_US, 2000, saturation limit on pulse width (< FRAME_US)
TIMEOUT_FRAMES, 20, frames without CMD_VALID before failsafe (0 = watchdog off)
SLEW_STEP, 16, max command change per frame (used only with optional feature)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
CMD  in  N_CH*CMD_W  channel commands, channel i at bits [i*CMD_W +: CMD_W]
CMD_VALID  in  1  single-cycle strobe; writes CMD into shadow registers
OFFSET  in  CMD_W  pulse offset added to every command
ARM  in  1  level; 1 = commands applied, 0 = commands forced to 0
SERVO  out  N_CH  pulse outputs
FRAME_START  out  1  one-cycle pulse at each frame start
TIMEOUT  out  1  failsafe active
ARMED  out  1  arm state actually in force this frame

Behaviour:
- Reset (RST_N low, asynchronous): all counters, shadow/active commands, pending flag, watchdog count cleared. SERVO=0, FRAME_START=0, TIMEOUT=0, ARMED=0.
- Prescaler: counts 0..CLK_DIV-1. tick = (prescaler == CLK_DIV-1).
- Frame counter fcnt: counts 0..FRAME_US-1 on tick, then wraps to 0.
- Boundary cycle B = tick && fcnt == FRAME_US-1.
- At B the following are registered and used for the whole next frame:
  - active_offset ← OFFSET
  - ARMED ← ARM && !timeout_next
  - active_cmd[i] ← shadow[i], if pending; otherwise unchanged.
  - pending cleared at B.
- FRAME_START is 1 in the cycle after B.
- CMD_VALID: shadow ← CMD and pending ← 1.
  - CMD_VALID in cycle B writes the shadow but is applied at the next boundary, not this one.
  - For the watchdog it counts as received in this frame.
- Watchdog: wdog counts frames (increments at B) since the last CMD_VALID; CMD_VALID clears it.
  - timeout_next = (TIMEOUT_FRAMES != 0) && wdog reaches TIMEOUT_FRAMES, saturating.
  - TIMEOUT updates only at B.
  - TIMEOUT clears at the first B after any CMD_VALID.
- Pulse width (µs):
  - eff_cmd = ARMED ? active_cmd[i] : 0
  - pw = min(active_offset + eff_cmd, MAX_PULSE_US), computed at CMD_W+1 bits, no wrap.
- SERVO[i] is registered: 1 while fcnt < pw. Latency from B to the rising edge is 1 cycle. pw = 0 gives a constant-low output.
- First frame after reset: active values are 0, so SERVO stays low until the first B.
- ARM/OFFSET changes mid-frame have no effect until B.
- A CMD_VALID burst within one frame: the last write wins.

Optional Feature:
Macro PWM_SERVO_BANK_SLEW_EN.
- Defined: at B, each active_cmd[i] moves toward shadow[i] by at most SLEW_STEP, saturating exactly at the target.
  - pending stays set until every channel has reached its target.
  - Disarm or TIMEOUT bypasses the slew: eff_cmd drops to 0 immediately. Re-arm ramps from the current active_cmd.
- Undefined: direct load, as above. SLEW_STEP is ignored.

Decomposition:
- Package pwm_servo_bank_pkg:
  - PW_W = CMD_W+1
  - clog2 helper for counter widths
  - default frame/limit constants
  - channel-slice indexing function
- Sub-module pwm_servo_channel, generated N_CH times. It holds active_cmd, the slew logic, the saturating adder and the compare register.
- Top level holds the prescaler, frame counter, shadow/pending logic, watchdog and arm register.

Test Plan:
- Reset/first frame (CLK_DIV=2, FRAME_US=1100, MAX_PULSE_US=1050, OFFSET=100): SERVO=0 for the first 2200 cycles. FRAME_START pulses first at cycle 2200, then every 2200 cycles.
- Armed, CMD={300,0,500,1023} via CMD_VALID mid-frame: next frame pulse widths are 400/100/600/1050 µs (1050 saturated) = 800/200/1200/2100 cycles. The current frame is unchanged.
- CMD_VALID asserted exactly in cycle B: takes effect one frame later. TIMEOUT_FRAMES=3 and no further CMD_VALID: TIMEOUT rises at the 4th B and all pulses become 100 µs. One CMD_VALID clears TIMEOUT at the next B.
- ARM dropped mid-pulse: the current pulse completes at full width; the next frame is 100 µs on all channels and ARMED=0.
- RST_N asserted mid-pulse: SERVO goes to 0 asynchronously in the same cycle; the counters restart from 0 on release.
- SLEW_EN, SLEW_STEP=16, 0→100 command step: successive frames use 16, 32, 48, 64, 80, 96, 100, and pending clears after 100.
